// File: rtl/shift_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one external right shifter/rotator
// between two requesters; the shifter result is registered onto a tagged result channel.
module shift_arbiter #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 4,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [CNT_W-1:0] req0_cnt,
  input  logic             req0_rot,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [CNT_W-1:0] req1_cnt,
  input  logic             req1_rot,
  output logic [WIDTH-1:0] sh_in,
  output logic [CNT_W-1:0] sh_cnt,
  output logic             sh_rot,
  input  logic [WIDTH-1:0] sh_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
);

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             can_accept;
  logic             grant0, grant1;

  // A new op is taken only when the result slot is empty or draining this cycle.
  always_comb begin
    can_accept = !res_valid_q || res_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRI || !rr_ptr_q) grant0 = 1'b1;
        else                        grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    sh_in  = '0;
    sh_cnt = '0;
    sh_rot = 1'b0;
    if (grant0) begin
      sh_in  = req0_data;
      sh_cnt = req0_cnt;
      sh_rot = req0_rot;
    end else if (grant1) begin
      sh_in  = req1_data;
      sh_cnt = req1_cnt;
      sh_rot = req1_rot;
    end
  end

  // Pointer moves to the side that lost, so the other requester is preferred next.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant0 || grant1) begin
      res_valid_d = 1'b1;
      res_data_d  = sh_out;
      res_id_d    = grant1;
      if (!FIXED_PRI) rr_ptr_d = !grant1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      rr_ptr_q    <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin and a fixed-priority instance share the
// requester inputs, each with its own shifter, and are checked against a bit-level model.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_rot, req1_rot, res_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_cnt, req1_cnt;

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic [1:0]  rdy0, rdy1, shrot, resv, resid;
  logic [15:0] shin [2];
  logic [15:0] shout[2];
  logic [15:0] resd [2];
  logic [3:0]  shcnt[2];

  int checks = 0;
  int errors = 0;

  bit          m_valid[2] = '{1'b0, 1'b0};
  logic [15:0] m_data [2] = '{16'h0, 16'h0};
  int          m_id   [2] = '{0, 0};
  int          m_pref     = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(16), .CNT_W(4), .FIXED_PRI(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_data(req0_data),
    .req0_cnt(req0_cnt), .req0_rot(req0_rot),
    .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_data(req1_data),
    .req1_cnt(req1_cnt), .req1_rot(req1_rot),
    .sh_in(shin[0]), .sh_cnt(shcnt[0]), .sh_rot(shrot[0]), .sh_out(shout[0]),
    .res_valid(resv[0]), .res_ready(res_ready), .res_data(resd[0]), .res_id(resid[0])
  );

  shift_arbiter #(.WIDTH(16), .CNT_W(4), .FIXED_PRI(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_data(req0_data),
    .req0_cnt(req0_cnt), .req0_rot(req0_rot),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_data(req1_data),
    .req1_cnt(req1_cnt), .req1_rot(req1_rot),
    .sh_in(shin[1]), .sh_cnt(shcnt[1]), .sh_rot(shrot[1]), .sh_out(shout[1]),
    .res_valid(resv[1]), .res_ready(res_ready), .res_data(resd[1]), .res_id(resid[1])
  );

  function automatic logic [15:0] shifter(input logic [15:0] d, input logic [3:0] c,
                                          input logic r);
    logic [31:0] t;
    t = {d, d} >> c;
    return r ? t[15:0] : (d >> c);
  endfunction

  assign shout[0] = shifter(shin[0], shcnt[0], shrot[0]);
  assign shout[1] = shifter(shin[1], shcnt[1], shrot[1]);

  // Reference result built bit by bit: bit i takes operand bit i+cnt, wrapping on rotate.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int c, input logic r);
    logic [15:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (i + c < 16) res[i] = d[i + c];
      else if (r)     res[i] = d[i + c - 16];
    end
    return res;
  endfunction

  // Which requester instance k should serve now, or -1 for none.
  function automatic int pick(input int k);
    if (m_valid[k] && !res_ready) return -1;
    if (req0_valid && req1_valid) return (k == 1) ? 0 : m_pref;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [15:0] d0, input logic [3:0] c0,
                               input logic r0, input logic v1, input logic [15:0] d1,
                               input logic [3:0] c1, input logic r1, input logic rdy);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_data = d0; req0_cnt = c0; req0_rot = r0;
    req1_valid = v1; req1_data = d1; req1_cnt = c1; req1_rot = r1;
    res_ready  = rdy;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = '{1'b0, 1'b0};
      m_data  = '{16'h0, 16'h0};
      m_id    = '{0, 0};
      m_pref  = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int g;
        g = pick(k);
        if (g >= 0) begin
          m_valid[k] = 1'b1;
          m_data[k]  = (g == 0) ? ref_shift(req0_data, int'(req0_cnt), req0_rot)
                                : ref_shift(req1_data, int'(req1_cnt), req1_rot);
          m_id[k]    = g;
          if (k == 0) m_pref = 1 - g;
        end else if (m_valid[k] && res_ready) begin
          m_valid[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        int          g;
        string       p;
        logic [15:0] ein;
        logic [3:0]  ecnt;
        logic        erot;
        g    = pick(k);
        p    = (k == 0) ? "rr" : "fp";
        ein  = (g == 0) ? req0_data : (g == 1) ? req1_data : 16'h0;
        ecnt = (g == 0) ? req0_cnt  : (g == 1) ? req1_cnt  : 4'h0;
        erot = (g == 0) ? req0_rot  : (g == 1) ? req1_rot  : 1'b0;
        checkOutput({p, "_req0_ready"}, 32'(rdy0[k]), 32'(g == 0));
        checkOutput({p, "_req1_ready"}, 32'(rdy1[k]), 32'(g == 1));
        checkOutput({p, "_sh_in"}, 32'(shin[k]), 32'(ein));
        checkOutput({p, "_sh_cnt"}, 32'(shcnt[k]), 32'(ecnt));
        checkOutput({p, "_sh_rot"}, 32'(shrot[k]), 32'(erot));
        checkOutput({p, "_res_valid"}, 32'(resv[k]), 32'(m_valid[k]));
        checkOutput({p, "_res_data"}, 32'(resd[k]), 32'(m_data[k]));
        checkOutput({p, "_res_id"}, 32'(resid[k]), 32'(m_id[k]));
      end
    end
  end

  initial begin
    logic        v0, v1, r0, r1, rd, g0, g1;
    logic [15:0] d0, d1, held;
    logic [3:0]  c0, c1;
    rst_n = 1'b0;
    req0_valid = 0; req0_data = 0; req0_cnt = 0; req0_rot = 0;
    req1_valid = 0; req1_data = 0; req1_cnt = 0; req1_rot = 0;
    res_ready = 0;
    #3;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_res_valid", 32'(resv[k]), 0);
      checkOutput("reset_res_data", 32'(resd[k]), 0);
      checkOutput("reset_res_id", 32'(resid[k]), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single logical shift from requester 0.
    applyStimulus(1, 16'hF0F0, 4, 0, 0, 16'h0, 0, 0, 1);
    #1 checkOutput("t2_req0_ready", 32'(rdy0[0]), 1);
    applyStimulus(0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 1);
    checkOutput("t2_res_valid", 32'(resv[0]), 1);
    checkOutput("t2_res_data", 32'(resd[0]), 32'h0F0F);
    checkOutput("t2_res_id", 32'(resid[0]), 0);

    // Single rotate from requester 1.
    applyStimulus(0, 16'h0, 0, 0, 1, 16'h8001, 1, 1, 1);
    #1 checkOutput("t3_req1_ready", 32'(rdy1[0]), 1);
    applyStimulus(0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 1);
    checkOutput("t3_res_data", 32'(resd[0]), 32'hC000);
    checkOutput("t3_res_id", 32'(resid[0]), 1);

    // Both valid continuously: RR alternates, fixed priority always picks req0.
    applyStimulus(1, 16'h1234, 3, 1, 1, 16'hABCD, 8, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) applyStimulus(1, 16'h1234, 3, 1, 1, 16'hABCD, 8, 0, 1);
      else       applyStimulus(0, 16'h0, 0, 0, 1, 16'hABCD, 8, 0, 1);
      checkOutput("t4_rr_res_id", 32'(resid[0]), 32'(i % 2));
      checkOutput("t4_rr_res_valid", 32'(resv[0]), 1);
      checkOutput("t6_fp_res_id", 32'(resid[1]), 0);
    end
    #1 checkOutput("t6_fp_req1_ready", 32'(rdy1[1]), 1);

    // Backpressure: three stalled cycles, then the grant follows the RR pointer.
    applyStimulus(1, 16'h00FF, 2, 0, 1, 16'hFF00, 5, 1, 0);
    held = resd[0];
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t5_rr_req0_ready", 32'(rdy0[0]), 0);
      checkOutput("t5_rr_req1_ready", 32'(rdy1[0]), 0);
      checkOutput("t5_rr_res_data", 32'(resd[0]), 32'(held));
      applyStimulus(1, 16'h00FF, 2, 0, 1, 16'hFF00, 5, 1, (i == 2));
    end
    #1 checkOutput("t5_rr_grant_after_stall", 32'({rdy1[0], rdy0[0]}), 32'h1);

    // Randomized traffic; requesters hold their op until the RR instance takes it.
    for (int n = 0; n < 600; n++) begin
      g0 = rdy0[0];
      g1 = rdy1[0];
      v0 = req0_valid; d0 = req0_data; c0 = req0_cnt; r0 = req0_rot;
      v1 = req1_valid; d1 = req1_data; c1 = req1_cnt; r1 = req1_rot;
      if (!(v0 && !g0)) begin
        v0 = 1'($urandom_range(0, 1)); d0 = 16'($urandom);
        c0 = 4'($urandom); r0 = 1'($urandom);
      end
      if (!(v1 && !g1)) begin
        v1 = 1'($urandom_range(0, 1)); d1 = 16'($urandom);
        c1 = 4'($urandom); r1 = 1'($urandom);
      end
      rd = ($urandom_range(0, 9) < 7);
      applyStimulus(v0, d0, c0, r0, v1, d1, c1, r1, rd);
    end

    // Asynchronous reset while a result is stalled.
    applyStimulus(1, 16'h5555, 2, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
    checkOutput("t1_rr_stalled_valid", 32'(resv[0]), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("t1_async_res_valid", 32'(resv[k]), 0);
      checkOutput("t1_async_res_data", 32'(resd[k]), 0);
      checkOutput("t1_async_res_id", 32'(resid[k]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1; req1_valid = 1; res_ready = 1;
    #1 checkOutput("t1_rr_ptr_after_reset", 32'({rdy1[0], rdy0[0]}), 32'h1);
    applyStimulus(0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 1);
    applyStimulus(0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
